// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V style load/store unit bridging the core to a word-wide memory port
//
// Purpose: accepts one load or store from the core, checks size and alignment,
// drives a word-aligned memory request with byte enables and replicated write
// data, extracts and extends load data, and optionally aborts on a memory
// timeout.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   core_req_i/we_i        access request and store select
//   core_size_i            funct3 size code (B, H, W, BU, HU)
//   core_addr_i/wd_i       byte address and store data
//   core_rd_o              extended load data, held until the next completed load
//   core_stall_o           core must hold its pipeline and inputs
//   core_err_o             one-cycle pulse on misaligned/illegal access or timeout
//   mem_req_o/we_o         memory request and write enable
//   mem_be_o               byte enables
//   mem_addr_o/wd_o        word address and replicated write data
//   mem_rd_i, mem_ready_i  memory read word and completion strobe

module load_store_unit #(
  parameter int TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW = $clog2(TIMEOUT + 2);
  // Counter value seen in the last BUSY cycle allowed before the abort.
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nx;
  logic [31:0]   addr_q, wd_q;
  logic          we_q;
  logic [2:0]    size_q;
  logic [CW-1:0] cnt;
  logic          bad_req, err_nx, capture;
  logic [31:0]   shifted, load_data;

  // Misaligned or illegal size on the incoming request.
  always_comb begin
    bad_req = 1'b0;
    case (core_size_i)
      3'd0, 3'd4: bad_req = 1'b0;
      3'd1, 3'd5: bad_req = core_addr_i[0];
      3'd2:       bad_req = |core_addr_i[1:0];
      default:    bad_req = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    err_nx       = 1'b0;
    capture      = 1'b0;
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    case (state)
      IDLE: begin
        core_stall_o = core_req_i;
        if (core_req_i) begin
          if (bad_req) begin
            state_nx = DONE;
            err_nx   = 1'b1;
          end else begin
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        core_stall_o = 1'b1;
        mem_req_o    = 1'b1;
        mem_we_o     = we_q;
        // Ready takes priority over a timeout firing in the same cycle.
        if (mem_ready_i) begin
          state_nx = DONE;
          capture  = ~we_q;
        end else if ((TIMEOUT > 0) && (cnt == TO_LAST)) begin
          state_nx = DONE;
          err_nx   = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      wd_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      cnt        <= '0;
      core_rd_o  <= '0;
      core_err_o <= 1'b0;
    end else begin
      core_err_o <= err_nx;
      if (state == IDLE && core_req_i) begin
        addr_q <= core_addr_i;
        wd_q   <= core_wd_i;
        we_q   <= core_we_i;
        size_q <= core_size_i;
        cnt    <= '0;
      end else if (state == BUSY && !mem_ready_i) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) core_rd_o <= load_data;
    end
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted = mem_rd_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd4:    load_data = {24'b0, shifted[7:0]};
      3'd5:    load_data = {16'b0, shifted[15:0]};
      default: load_data = mem_rd_i;
    endcase
  end

  assign mem_addr_o = {addr_q[31:2], 2'b00};

  always_comb begin
    mem_be_o = 4'b1111;
    mem_wd_o = wd_q;
    case (size_q)
      3'd0, 3'd4: begin
        mem_be_o = 4'b0001 << addr_q[1:0];
        mem_wd_o = {4{wd_q[7:0]}};
      end
      3'd1, 3'd5: begin
        mem_be_o = 4'b0011 << addr_q[1:0];
        mem_wd_o = {2{wd_q[15:0]}};
      end
      default: begin
        mem_be_o = 4'b1111;
        mem_wd_o = wd_q;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a behavioural model

module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req = 1'b0;
  logic        core_we = 1'b0;
  logic [2:0]  core_size = '0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wd = '0;
  logic [31:0] mem_rd = '0;
  logic        mem_ready = 1'b0;

  logic [31:0] core_rd;
  logic        core_stall, core_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_rd = '0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .core_req_i  (core_req),
    .core_we_i   (core_we),
    .core_size_i (core_size),
    .core_addr_i (core_addr),
    .core_wd_i   (core_wd),
    .core_rd_o   (core_rd),
    .core_stall_o(core_stall),
    .core_err_o  (core_err),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wd_o    (mem_wd),
    .mem_rd_i    (mem_rd),
    .mem_ready_i (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit is_bad(input logic [2:0] sz, input logic [31:0] a);
    if (sz == 3'd0 || sz == 3'd4) return 1'b0;
    if (sz == 3'd1 || sz == 3'd5) return (a % 2) != 0;
    if (sz == 3'd2) return (a % 4) != 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] a);
    int o = int'(a % 4);
    if (sz == 3'd2) return 4'hF;
    if (sz == 3'd1 || sz == 3'd5) return 4'(3 << o);
    return 4'(1 << o);
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] sz, input logic [31:0] wd);
    if (sz == 3'd0 || sz == 3'd4) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 3'd1 || sz == 3'd5) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rdata);
    int o = int'(a % 4);
    logic [31:0] b = (rdata >> (8 * o)) & 32'hFF;
    logic [31:0] h = (rdata >> (8 * o)) & 32'hFFFF;
    if (sz == 3'd0) return (b >= 128) ? b - 32'd256 : b;
    if (sz == 3'd1) return (h >= 32768) ? h - 32'd65536 : h;
    if (sz == 3'd4) return b;
    if (sz == 3'd5) return h;
    return rdata;
  endfunction

  // ready_at: BUSY cycle (1-based) in which mem_ready is raised; beyond TMO means never.
  task automatic access(input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata,
                        input int ready_at, input bit hold_done);
    bit bad;
    bit tmo;
    bit got_ready;
    bad = is_bad(sz, a);
    tmo = 1'b0;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = wd;
    mem_rd = rdata; mem_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_stall", core_stall, 1);
    check_eq("idle_memreq", mem_req, 0);
    if (!bad) begin
      for (int k = 1; k <= TMO; k++) begin
        @(posedge clk); #1;
        mem_ready = (k == ready_at);
        got_ready = mem_ready;
        @(negedge clk);
        check_eq("busy_memreq", mem_req, 1);
        check_eq("busy_stall", core_stall, 1);
        check_eq("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
        check_eq("busy_be", mem_be, exp_be(sz, a));
        check_eq("busy_we", mem_we, we);
        if (we) check_eq("busy_wd", mem_wd, exp_wd(sz, wd));
        if (got_ready) break;
        if (k == TMO) tmo = 1'b1;
      end
      if (!tmo && !we) exp_rd = exp_load(sz, a, rdata);
    end
    @(posedge clk); #1;
    core_req = hold_done;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("done_stall", core_stall, 0);
    check_eq("done_memreq", mem_req, 0);
    check_eq("done_memwe", mem_we, 0);
    check_eq("done_err", core_err, bad | tmo);
    check_eq("done_rd", core_rd, exp_rd);
    @(posedge clk); #1;
    core_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check_eq("post_err", core_err, 0);
    check_eq("post_stall", core_stall, 0);
    check_eq("post_memreq", mem_req, 0);
    check_eq("post_rd", core_rd, exp_rd);
  endtask

  initial begin
    bit          r_we;
    logic [2:0]  r_sz;
    logic [31:0] r_addr;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", core_stall, 0);
    check_eq("rst_memreq", mem_req, 0);
    check_eq("rst_err", core_err, 0);
    check_eq("rst_rd", core_rd, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LW, ready in 2nd BUSY cycle
    access(1'b0, 3'd2, 32'h104, 32'h0, 32'hDEADBEEF, 2, 1'b0);
    check_eq("lw_rd", core_rd, 32'hDEADBEEF);
    // byte/half extraction
    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
    check_eq("lb_rd", core_rd, 32'hFFFFFF80);
    access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 3, 1'b1);
    check_eq("lbu_rd", core_rd, 32'h00000080);
    access(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF0000, 1, 1'b0);
    check_eq("lhu_rd", core_rd, 32'h000080FF);
    // SH: store must not disturb load data
    access(1'b1, 3'd1, 32'h206, 32'h1234ABCD, 32'h0, 2, 1'b0);
    check_eq("sh_rd_kept", core_rd, 32'h000080FF);
    // misaligned and illegal
    access(1'b0, 3'd2, 32'h101, 32'h0, 32'h11111111, 1, 1'b0);
    access(1'b0, 3'd3, 32'h100, 32'h0, 32'h22222222, 1, 1'b0);
    check_eq("err_rd_kept", core_rd, 32'h000080FF);
    // timeout and ready on the last allowed cycle
    access(1'b0, 3'd2, 32'h300, 32'h0, 32'h33333333, TMO + 3, 1'b0);
    access(1'b0, 3'd2, 32'h300, 32'h0, 32'h44444444, TMO, 1'b0);
    check_eq("tmo_edge_rd", core_rd, 32'h44444444);

    // reset in 2nd BUSY cycle with ready high
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h80; mem_rd = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; core_req = 1'b0; mem_ready = 1'b0;
    exp_rd = '0;
    @(negedge clk);
    check_eq("rstbusy_memreq", mem_req, 0);
    check_eq("rstbusy_stall", core_stall, 0);
    check_eq("rstbusy_err", core_err, 0);
    check_eq("rstbusy_rd", core_rd, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rstbusy_err2", core_err, 0);
    check_eq("rstbusy_rd2", core_rd, 0);

    for (int i = 0; i < 300; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_sz = 3'($urandom_range(0, 7));
      if (r_we && (r_sz == 3'd4 || r_sz == 3'd5)) r_sz = r_sz - 3'd4;
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
      access(r_we, r_sz, r_addr, $urandom, $urandom, $urandom_range(1, TMO + 2),
             1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 0, max cycles in BUSY without mem_ready_i before abort; 0 disables the timeout.
REQ-002 One clock; reset is synchronous and active-high. Ports are clk_i and rst_i.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 core_req_i  input  1  core requests a memory access; held high while core_stall_o=1.
REQ-006 core_we_i  input  1  1=store, 0=load.
REQ-007 core_size_i  input  3  RISC-V funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU; other codes are illegal.
REQ-008 core_addr_i  input  32  byte address, taken from the ALU result.
REQ-009 core_wd_i  input  32  store data; only the low bits are used for B and H.
REQ-010 core_rd_o  output  32  load data, extended to 32 bits.
REQ-011 core_stall_o  output  1  core must hold its pipeline and inputs.
REQ-012 core_err_o  output  1  one-cycle pulse: misaligned access, illegal size, or timeout.
REQ-013 mem_req_o, mem_we_o  output  1 each  memory request and write enable.
REQ-014 mem_be_o  output  4  byte enables.
REQ-015 mem_addr_o, mem_wd_o  output  32 each  word-aligned address and replicated write data.
REQ-016 mem_rd_i  input  32  memory read word.
REQ-017 mem_ready_i  input  1  memory completes the access this cycle.

Function
REQ-018 FSM states are IDLE, BUSY and DONE; reset state is IDLE.
REQ-019 IDLE with core_req_i=1: latch addr, we, size and wd; go to BUSY, or go to DONE with core_err_o=1 if the access is misaligned or illegal.
REQ-020 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. A misaligned or illegal-size access shall issue no memory request.
REQ-021 core_stall_o = (IDLE & core_req_i) | BUSY, combinational; it is 0 in DONE.
REQ-022 In BUSY: mem_req_o=1, and all mem_* outputs shall stay constant, driven from latched values, until the cycle mem_ready_i=1.
REQ-023 In BUSY with mem_ready_i=1: for loads, register the extended data into core_rd_o; go to DONE.
REQ-024 DONE lasts exactly one cycle, then returns to IDLE; core_req_i is ignored in DONE (it is the completing instruction).
REQ-025 mem_addr_o = {addr[31:2], 2'b00}.
REQ-026 mem_be_o: B = 4'b0001 << addr[1:0]; H = 4'b0011 << addr[1:0]; W = 4'b1111; loads drive the same enables.
REQ-027 mem_wd_o: B = {4{wd[7:0]}}; H = {2{wd[15:0]}}; W = wd.
REQ-028 Load extraction: select the byte or half at addr[1:0]; B and H sign-extend, BU and HU zero-extend, W passes through.
REQ-029 core_rd_o holds its value until the next completed load; stores and errors leave core_rd_o unchanged.
REQ-030 Timeout (TIMEOUT>0): the counter clears on BUSY entry and increments each BUSY cycle without ready. On reaching TIMEOUT: drop mem_req_o, pulse core_err_o, go to DONE.
REQ-031 If mem_ready_i=1 in the same cycle the timeout would fire, ready wins: normal completion, no error.
REQ-032 Outside BUSY: mem_req_o=0 and mem_we_o=0.
REQ-033 mem_ready_i outside BUSY is ignored.

Reset
REQ-034 rst_i=1 forces IDLE, clears the timeout counter, core_rd_o=0 and core_err_o=0; mem_req_o=0 from the following cycle.
REQ-035 rst_i asserted in BUSY aborts the access: no data capture and no error pulse, even if mem_ready_i=1 in the same cycle.

Verification
REQ-036 LW, addr=0x104, mem_rd_i=0xDEADBEEF, ready after 2 BUSY cycles -> mem_addr_o=0x104, be=1111; stall high 3 cycles; core_rd_o=0xDEADBEEF in DONE.
REQ-037 LB, addr=0x103, mem_rd_i=0x80FF0000 -> core_rd_o=0xFFFFFF80; LBU same -> 0x00000080; LHU at 0x102 -> 0x000080FF.
REQ-038 SH, addr=0x206, wd=0x1234ABCD -> mem_addr_o=0x204, be=1100, mem_wd_o=0xABCDABCD, mem_we_o=1.
REQ-039 LW at 0x101, and size=3 -> no mem_req_o; core_err_o pulses for 1 cycle; stall high 1 cycle.
REQ-040 TIMEOUT=4, ready never asserted -> mem_req_o high 4 cycles, then err pulse; ready coinciding with the 4th cycle -> normal completion.
REQ-041 rst_i in 2nd BUSY cycle with mem_ready_i=1 -> IDLE next cycle, core_rd_o=0, no err, mem_req_o=0.
